i2c_tmp_responder: RTL and testbench

I2C slave that answers the TMP421-style pointer-write / 2-byte-read transactions. It lets the wsn-soc I2C master and its query FSM run against an on-chip, register-accurate target in simulation and FPGA loopback. It decodes START/STOP, matches a 7-bit address, holds an 8-bit pointer register and serves 16-bit temperature values supplied from ports. It drives SDA open-drain only, never SCL, so it does no clock stretching.

---
 rtl/i2c_tmp_pkg.sv | 33 +++
 rtl/i2c_line_cond.sv | 63 ++++++
 rtl/i2c_tmp_responder.sv | 213 +++++++++++++++++++++
 tb/tb_i2c_tmp_responder.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/i2c_tmp_pkg.sv
// Shared types and constants for the TMP421-style I2C responder.
package i2c_tmp_pkg;

    typedef enum logic [2:0] {
        stIdle,
        stAddr,
        stAddrAck,
        stWrByte,
        stWrAck,
        stRdByte,
        stRdAck,
        stIgnore
    } state_t;

    localparam logic [6:0] DefaultAddr = 7'b1001100;
    localparam logic [7:0] PtrLocal    = 8'h00;
    localparam logic [7:0] PtrRemote   = 8'h01;

    // Unmapped pointers read as zero but are still acknowledged.
    function automatic logic [15:0] sel_reg(input logic [7:0]  ptr,
                                            input logic [15:0] local_t,
                                            input logic [15:0] remote_t);
        logic [15:0] word;
        word = 16'h0000;
        if (ptr == PtrLocal) begin
            word = local_t;
        end else if (ptr == PtrRemote) begin
            word = remote_t;
        end
        return word;
    endfunction

endpackage

// File: rtl/i2c_line_cond.sv
// Synchronizes SCL/SDA into the system clock and produces registered bus events.
module i2c_line_cond (
    input  logic Clk_i,
    input  logic Reset_n_i,
    input  logic SCL_i,
    input  logic SDA_i,
    output logic SclRise,
    output logic SclFall,
    output logic Start,
    output logic Stop,
    output logic Sda
);

    logic [1:0] scl_sync_q, scl_sync_d;
    logic [1:0] sda_sync_q, sda_sync_d;
    logic       scl_prev_q, scl_prev_d;
    logic       sda_prev_q, sda_prev_d;
    logic       scl_rise_q, scl_rise_d;
    logic       scl_fall_q, scl_fall_d;
    logic       start_q, start_d;
    logic       stop_q, stop_d;

    always_comb begin
        scl_sync_d = {scl_sync_q[0], SCL_i};
        sda_sync_d = {sda_sync_q[0], SDA_i};
        scl_prev_d = scl_sync_q[1];
        sda_prev_d = sda_sync_q[1];
        scl_rise_d = scl_sync_q[1] & ~scl_prev_q;
        scl_fall_d = ~scl_sync_q[1] & scl_prev_q;
        // SDA transitions only count as START/STOP while SCL is steadily high.
        start_d    = scl_sync_q[1] & scl_prev_q & sda_prev_q & ~sda_sync_q[1];
        stop_d     = scl_sync_q[1] & scl_prev_q & ~sda_prev_q & sda_sync_q[1];
    end

    always_ff @(posedge Clk_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            scl_rise_q <= 1'b0;
            scl_fall_q <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
            scl_rise_q <= scl_rise_d;
            scl_fall_q <= scl_fall_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
        end
    end

    assign SclRise = scl_rise_q;
    assign SclFall = scl_fall_q;
    assign Start   = start_q;
    assign Stop    = stop_q;
    assign Sda     = sda_prev_q;

endmodule

// File: rtl/i2c_tmp_responder.sv
// I2C target answering pointer writes and 2-byte temperature reads; drives SDA open-drain only.
module i2c_tmp_responder
    import i2c_tmp_pkg::*;
#(
    parameter logic [6:0] Address = DefaultAddr
) (
    input  logic        Clk_i,
    input  logic        Reset_n_i,
    input  logic        SCL_i,
    input  logic        SDA_i,
    output logic        SDA_DrvLow_o,
    input  logic [15:0] LocalTemp_i,
    input  logic [15:0] RemoteTemp_i,
    output logic [7:0]  Pointer_o,
    output logic        Busy_o,
    output logic        ReadDone_o
);

    logic scl_rise, scl_fall, start, stop, sda;

    i2c_line_cond u_line_cond (
        .Clk_i     (Clk_i),
        .Reset_n_i (Reset_n_i),
        .SCL_i     (SCL_i),
        .SDA_i     (SDA_i),
        .SclRise   (scl_rise),
        .SclFall   (scl_fall),
        .Start     (start),
        .Stop      (stop),
        .Sda       (sda)
    );

    state_t      state_q, state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [6:0]  shift_q, shift_d;
    logic [7:0]  tx_q, tx_d;
    logic [7:0]  snap_q, snap_d;
    logic [7:0]  ptr_q, ptr_d;
    logic        byte_idx_q, byte_idx_d;
    logic        rw_q, rw_d;
    logic        first_q, first_d;
    logic        sda_drv_q, sda_drv_d;
    logic        busy_q, busy_d;
    logic        rd_done_q, rd_done_d;

    logic [15:0] sel_word;
    logic [7:0]  next_byte;
    logic        load, load_lsb;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        snap_d     = snap_q;
        ptr_d      = ptr_q;
        byte_idx_d = byte_idx_q;
        rw_d       = rw_q;
        first_d    = first_q;
        sda_drv_d  = sda_drv_q;
        busy_d     = busy_q;
        rd_done_d  = 1'b0;
        load       = 1'b0;
        load_lsb   = 1'b0;
        next_byte  = 8'h00;
        sel_word   = sel_reg(ptr_q, LocalTemp_i, RemoteTemp_i);

        if (start) begin
            state_d    = stAddr;
            bit_cnt_d  = 4'd0;
            byte_idx_d = 1'b0;
            sda_drv_d  = 1'b0;
        end else if (stop) begin
            state_d   = stIdle;
            sda_drv_d = 1'b0;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                stAddr: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[5:0], sda};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            if (shift_q == Address) begin
                                state_d = stAddrAck;
                                busy_d  = 1'b1;
                                rw_d    = sda;
                                first_d = 1'b1;
                            end else begin
                                state_d = stIgnore;
                                busy_d  = 1'b0;
                            end
                        end
                    end
                end
                // First fall ends bit 8 and starts the ACK; second fall ends bit 9.
                stAddrAck: begin
                    if (scl_fall) begin
                        if (!sda_drv_q) begin
                            sda_drv_d = 1'b1;
                        end else if (rw_q) begin
                            load = 1'b1;
                        end else begin
                            sda_drv_d = 1'b0;
                            state_d   = stWrByte;
                            bit_cnt_d = 4'd0;
                        end
                    end
                end
                stWrByte: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[5:0], sda};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            state_d = stWrAck;
                            if (first_q) begin
                                ptr_d   = {shift_q, sda};
                                first_d = 1'b0;
                            end
                        end
                    end
                end
                stWrAck: begin
                    if (scl_fall) begin
                        if (!sda_drv_q) begin
                            sda_drv_d = 1'b1;
                        end else begin
                            sda_drv_d = 1'b0;
                            state_d   = stWrByte;
                            bit_cnt_d = 4'd0;
                        end
                    end
                end
                stRdByte: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd0) begin
                            load     = 1'b1;
                            load_lsb = ~byte_idx_q;
                        end else if (bit_cnt_q == 4'd8) begin
                            sda_drv_d = 1'b0;
                            state_d   = stRdAck;
                        end else begin
                            sda_drv_d = ~tx_q[7];
                            tx_d      = {tx_q[6:0], 1'b0};
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
                stRdAck: begin
                    if (scl_rise) begin
                        rd_done_d = byte_idx_q;
                        if (!sda) begin
                            state_d   = stRdByte;
                            bit_cnt_d = 4'd0;
                        end else begin
                            state_d = stIgnore;
                        end
                    end
                end
                default: ;
            endcase
        end

        // MSB loads capture the LSB in the same cycle so a word is never torn.
        if (load) begin
            next_byte = load_lsb ? snap_q : sel_word[15:8];
            if (!load_lsb) begin
                snap_d = sel_word[7:0];
            end
            byte_idx_d = load_lsb;
            sda_drv_d  = ~next_byte[7];
            tx_d       = {next_byte[6:0], 1'b0};
            bit_cnt_d  = 4'd1;
            state_d    = stRdByte;
        end
    end

    always_ff @(posedge Clk_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            state_q    <= stIdle;
            bit_cnt_q  <= 4'd0;
            shift_q    <= 7'd0;
            tx_q       <= 8'd0;
            snap_q     <= 8'd0;
            ptr_q      <= PtrLocal;
            byte_idx_q <= 1'b0;
            rw_q       <= 1'b0;
            first_q    <= 1'b0;
            sda_drv_q  <= 1'b0;
            busy_q     <= 1'b0;
            rd_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            snap_q     <= snap_d;
            ptr_q      <= ptr_d;
            byte_idx_q <= byte_idx_d;
            rw_q       <= rw_d;
            first_q    <= first_d;
            sda_drv_q  <= sda_drv_d;
            busy_q     <= busy_d;
            rd_done_q  <= rd_done_d;
        end
    end

    assign SDA_DrvLow_o = sda_drv_q;
    assign Pointer_o    = ptr_q;
    assign Busy_o       = busy_q;
    assign ReadDone_o   = rd_done_q;

endmodule

// File: tb/tb_i2c_tmp_responder.sv
// Directed bench: a bit-banged I2C master exercising writes, reads, mismatch and reset.
module tb_i2c_tmp_responder;

    localparam int Q = 10;

    logic        Clk_i = 1'b0;
    logic        Reset_n_i;
    logic        scl_m, sda_m;
    logic        sda_line;
    logic        SDA_DrvLow_o;
    logic [15:0] LocalTemp_i, RemoteTemp_i;
    logic [7:0]  Pointer_o;
    logic        Busy_o, ReadDone_o;

    int checks = 0;
    int failures = 0;
    int rd_cnt = 0;
    int rd_base;
    logic       ack, s;
    logic [7:0] d;

    assign sda_line = sda_m & ~SDA_DrvLow_o;

    i2c_tmp_responder dut (
        .Clk_i        (Clk_i),
        .Reset_n_i    (Reset_n_i),
        .SCL_i        (scl_m),
        .SDA_i        (sda_line),
        .SDA_DrvLow_o (SDA_DrvLow_o),
        .LocalTemp_i  (LocalTemp_i),
        .RemoteTemp_i (RemoteTemp_i),
        .Pointer_o    (Pointer_o),
        .Busy_o       (Busy_o),
        .ReadDone_o   (ReadDone_o)
    );

    always #5 Clk_i = ~Clk_i;

    always @(posedge Clk_i) if (ReadDone_o) rd_cnt <= rd_cnt + 1;

    initial begin
        #2ms;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wq();
        repeat (Q) @(negedge Clk_i);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wq();
        scl_m = 1'b1; wq();
        sda_m = 1'b0; wq();
        scl_m = 1'b0; wq();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wq();
        scl_m = 1'b1; wq();
        sda_m = 1'b1; wq(); wq();
    endtask

    task automatic bus_bit(input logic b, output logic smp);
        sda_m = b;    wq();
        scl_m = 1'b1; wq();
        smp = sda_line; wq();
        scl_m = 1'b0; wq();
    endtask

    task automatic write_byte(input logic [7:0] v, output logic a);
        logic t;
        for (int i = 7; i >= 0; i--) bus_bit(v[i], t);
        bus_bit(1'b1, t);
        a = ~t;
    endtask

    task automatic read_byte(input logic mack, input int chg_bit, output logic [7:0] v);
        logic t;
        v = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (i == chg_bit) LocalTemp_i = 16'h1BF0;
            bus_bit(1'b1, t);
            v = {v[6:0], t};
        end
        bus_bit(mack, t);
    endtask

    task automatic write_ptr(input logic [7:0] p);
        logic a;
        i2c_start();
        write_byte(8'h98, a); chk("wp_addr_ack", 16'(a), 16'd1);
        write_byte(p, a);     chk("wp_data_ack", 16'(a), 16'd1);
        i2c_stop();
    endtask

    task automatic read2(input logic [15:0] exp);
        logic a;
        logic [7:0] v;
        rd_base = rd_cnt;
        i2c_start();
        write_byte(8'h99, a);   chk("rd_addr_ack", 16'(a), 16'd1);
        read_byte(1'b0, -1, v); chk("rd_msb", 16'(v), 16'(exp[15:8]));
        read_byte(1'b1, -1, v); chk("rd_lsb", 16'(v), 16'(exp[7:0]));
        i2c_stop();
        chk("rd_done_cnt", 16'(rd_cnt - rd_base), 16'd1);
    endtask

    initial begin
        Reset_n_i    = 1'b0;
        scl_m        = 1'b1;
        sda_m        = 1'b1;
        LocalTemp_i  = 16'h1A50;
        RemoteTemp_i = 16'hE730;
        repeat (5) @(negedge Clk_i);
        chk("rst_sda", 16'(SDA_DrvLow_o), 16'd0);
        chk("rst_ptr", 16'(Pointer_o), 16'h00);
        chk("rst_busy", 16'(Busy_o), 16'd0);
        chk("rst_rddone", 16'(ReadDone_o), 16'd0);
        Reset_n_i = 1'b1;
        wq();

        // Local read
        write_ptr(8'h00);
        read2(16'h1A50);
        chk("local_ptr", 16'(Pointer_o), 16'h00);

        // Remote read through a repeated START
        i2c_start();
        write_byte(8'h98, ack); chk("rs_addr_ack", 16'(ack), 16'd1);
        chk("rs_busy_addr", 16'(Busy_o), 16'd1);
        write_byte(8'h01, ack); chk("rs_ptr_ack", 16'(ack), 16'd1);
        chk("rs_busy_ptr", 16'(Busy_o), 16'd1);
        i2c_start();
        chk("rs_busy_rstart", 16'(Busy_o), 16'd1);
        write_byte(8'h99, ack); chk("rs_rd_ack", 16'(ack), 16'd1);
        read_byte(1'b0, -1, d); chk("rs_msb", 16'(d), 16'h00E7);
        chk("rs_busy_msb", 16'(Busy_o), 16'd1);
        read_byte(1'b1, -1, d); chk("rs_lsb", 16'(d), 16'h0030);
        chk("rs_busy_lsb", 16'(Busy_o), 16'd1);
        i2c_stop();
        chk("rs_busy_stop", 16'(Busy_o), 16'd0);
        chk("rs_ptr", 16'(Pointer_o), 16'h01);

        // Address mismatch
        i2c_start();
        write_byte(8'h90, ack); chk("mm_nack", 16'(ack), 16'd0);
        chk("mm_busy", 16'(Busy_o), 16'd0);
        i2c_stop();
        chk("mm_ptr", 16'(Pointer_o), 16'h01);

        // Snapshot: Local changes while the MSB is on the bus
        write_ptr(8'h00);
        i2c_start();
        write_byte(8'h99, ack); chk("sn_addr_ack", 16'(ack), 16'd1);
        read_byte(1'b0, 3, d);  chk("sn_msb", 16'(d), 16'h001A);
        read_byte(1'b1, -1, d); chk("sn_lsb", 16'(d), 16'h0050);
        i2c_stop();
        LocalTemp_i = 16'h1A50;

        // Invalid pointer plus a discarded extra byte
        i2c_start();
        write_byte(8'h98, ack); chk("ip_addr_ack", 16'(ack), 16'd1);
        write_byte(8'h07, ack); chk("ip_ptr_ack", 16'(ack), 16'd1);
        write_byte(8'h55, ack); chk("ip_extra_ack", 16'(ack), 16'd1);
        i2c_stop();
        chk("ip_ptr", 16'(Pointer_o), 16'h07);
        read2(16'h0000);

        // Reset while the slave drives a 0 bit of the MSB
        write_ptr(8'h00);
        i2c_start();
        write_byte(8'h99, ack); chk("rr_addr_ack", 16'(ack), 16'd1);
        bus_bit(1'b1, s);
        bus_bit(1'b1, s);
        sda_m = 1'b1; wq();
        scl_m = 1'b1; wq();
        chk("rr_drv_before", 16'(SDA_DrvLow_o), 16'd1);
        Reset_n_i = 1'b0;
        #1;
        chk("rr_sda_rel", 16'(SDA_DrvLow_o), 16'd0);
        chk("rr_busy", 16'(Busy_o), 16'd0);
        chk("rr_ptr", 16'(Pointer_o), 16'h00);
        chk("rr_rddone", 16'(ReadDone_o), 16'd0);
        @(negedge Clk_i);
        scl_m = 1'b0; wq();
        Reset_n_i = 1'b1; wq();
        i2c_stop();
        read2(16'h1A50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
